// File: rtl/led_div_pkg.sv
// Shared types and default constants for the LED divider control stage.
package led_div_pkg;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_CALC  = 2'd2,
    ST_WRITE = 2'd3
  } state_e;

  localparam int DIV_W        = 12;
  localparam int DIV_MIN      = 1;
  localparam int DIV_MAX      = 4095;
  localparam int DIV_STEP     = 16;
  localparam int DIV_INIT     = 256;
  localparam int DEBOUNCE_CYC = 1000000;

endpackage

// File: rtl/btn_debounce.sv
// Raw pushbutton -> 2-FF synchronizer -> stability counter -> single-cycle press pulse.
module btn_debounce #(
  parameter int DEBOUNCE_CYC = led_div_pkg::DEBOUNCE_CYC
) (
  input  logic clk100,
  input  logic rstn,
  input  logic btn_i,
  output logic press_o
);

  localparam int            CW      = $clog2(DEBOUNCE_CYC);
  localparam logic [CW-1:0] CNT_END = CW'(DEBOUNCE_CYC - 1);

  logic [1:0]    sync;
  logic          deb;
  logic          deb_q;
  logic [CW-1:0] cnt;

  // two-stage synchronizer for the asynchronous button
  always_ff @(posedge clk100 or negedge rstn) begin
    if (!rstn) sync <= '0;
    else       sync <= {sync[0], btn_i};
  end

  // accept a new level only after it has differed from the debounced one long enough
  always_ff @(posedge clk100 or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
      deb <= 1'b0;
    end else if (sync[1] == deb) begin
      cnt <= '0;
    end else if (cnt == CNT_END) begin
      cnt <= '0;
      deb <= ~deb;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // delayed copy for rising-edge detection; releases are ignored
  always_ff @(posedge clk100 or negedge rstn) begin
    if (!rstn) deb_q <= 1'b0;
    else       deb_q <= deb;
  end

  assign press_o = deb & ~deb_q;

endmodule

// File: rtl/led_div_ctrl.sv
// Divider owner: merges button presses and software loads into saturated
// divider updates, each announced by a single-cycle write strobe.
module led_div_ctrl #(
  parameter int DEBOUNCE_CYC = led_div_pkg::DEBOUNCE_CYC,
  parameter int DIV_W        = led_div_pkg::DIV_W,
  parameter int DIV_MIN      = led_div_pkg::DIV_MIN,
  parameter int DIV_MAX      = led_div_pkg::DIV_MAX,
  parameter int DIV_STEP     = led_div_pkg::DIV_STEP,
  parameter int DIV_INIT     = led_div_pkg::DIV_INIT
) (
  input  logic             clk100,
  input  logic             rstn,
  input  logic             btn_up_i,
  input  logic             btn_dn_i,
  input  logic [DIV_W-1:0] sw_div_i,
  input  logic             sw_load_i,
  output logic [DIV_W-1:0] div_o,
  output logic             wren_o,
  output logic             sat_o
);

  import led_div_pkg::state_e;
  import led_div_pkg::ST_INIT;
  import led_div_pkg::ST_IDLE;
  import led_div_pkg::ST_CALC;
  import led_div_pkg::ST_WRITE;

  localparam logic [DIV_W-1:0] MIN_V  = DIV_W'(DIV_MIN);
  localparam logic [DIV_W-1:0] MAX_V  = DIV_W'(DIV_MAX);
  localparam logic [DIV_W-1:0] INIT_V = DIV_W'(DIV_INIT);
  localparam logic [DIV_W:0]   STEP_X = (DIV_W+1)'(DIV_STEP);

  state_e           state, state_nx;
  logic [1:0]       btn_raw, press;
  logic             p_up, p_dn, p_ld;
  logic [DIV_W-1:0] ld_val, nxt, nxt_q;
  logic [DIV_W:0]   sum, dif;
  logic             consume, wr;

  assign btn_raw = {btn_dn_i, btn_up_i};

  for (genvar g = 0; g < 2; g++) begin : g_btn
    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb (
      .clk100  (clk100),
      .rstn    (rstn),
      .btn_i   (btn_raw[g]),
      .press_o (press[g])
    );
  end

  // sticky request flags; a new event in the consuming cycle wins over the clear
  always_ff @(posedge clk100 or negedge rstn) begin
    if (!rstn) begin
      p_up   <= 1'b0;
      p_dn   <= 1'b0;
      p_ld   <= 1'b0;
      ld_val <= '0;
    end else begin
      p_up <= (p_up & ~consume) | press[0];
      p_dn <= (p_dn & ~consume) | press[1];
      p_ld <= (p_ld & ~consume) | sw_load_i;
      if (sw_load_i) ld_val <= sw_div_i;
    end
  end

  // candidate divider: load beats buttons, opposing presses cancel, one extra bit catches wrap
  always_comb begin
    sum = {1'b0, div_o} + STEP_X;
    dif = {1'b0, div_o} - STEP_X;
    nxt = div_o;
    if (p_ld) begin
      if (ld_val < MIN_V)      nxt = MIN_V;
      else if (ld_val > MAX_V) nxt = MAX_V;
      else                     nxt = ld_val;
    end else if (p_up && p_dn) begin
      nxt = div_o;
    end else if (p_up) begin
      nxt = (sum > {1'b0, MAX_V}) ? MAX_V : sum[DIV_W-1:0];
    end else if (p_dn) begin
      nxt = (dif[DIV_W] || (dif[DIV_W-1:0] < MIN_V)) ? MIN_V : dif[DIV_W-1:0];
    end
  end

  // state register
  always_ff @(posedge clk100 or negedge rstn) begin
    if (!rstn) state <= ST_INIT;
    else       state <= state_nx;
  end

  // next state: skip the write when the result would not change the divider
  always_comb begin
    state_nx = state;
    case (state)
      ST_INIT:  state_nx = ST_WRITE;
      ST_IDLE:  if (p_up || p_dn || p_ld) state_nx = ST_CALC;
      ST_CALC:  state_nx = (nxt == div_o) ? ST_IDLE : ST_WRITE;
      ST_WRITE: state_nx = ST_IDLE;
      default:  state_nx = ST_INIT;
    endcase
  end

  // state decodes
  always_comb begin
    consume = (state == ST_CALC);
    wr      = (state == ST_WRITE);
  end

  // registered datapath: result latched in CALC, published with the strobe from WRITE
  always_ff @(posedge clk100 or negedge rstn) begin
    if (!rstn) begin
      nxt_q  <= INIT_V;
      div_o  <= INIT_V;
      wren_o <= 1'b0;
    end else begin
      wren_o <= wr;
      if (consume) nxt_q <= nxt;
      if (wr)      div_o <= nxt_q;
    end
  end

  assign sat_o = (div_o == MIN_V) || (div_o == MAX_V);

endmodule

// File: tb/tb_led_div_ctrl.sv
// Bench for led_div_ctrl with a short debounce window: directed table,
// hand-written reset sequences and random transactions against a value model.
module tb_led_div_ctrl;

  localparam int D = 8;

  logic        clk100 = 1'b0;
  logic        rstn = 1'b0;
  logic        btn_up_i = 1'b0, btn_dn_i = 1'b0, sw_load_i = 1'b0;
  logic [11:0] sw_div_i = '0;
  logic [11:0] div_o;
  logic        wren_o, sat_o;

  int total = 0, bad = 0, b2b = 0;
  logic prev_w = 1'b0;

  led_div_ctrl #(.DEBOUNCE_CYC(D)) dut (
    .clk100    (clk100),
    .rstn      (rstn),
    .btn_up_i  (btn_up_i),
    .btn_dn_i  (btn_dn_i),
    .sw_div_i  (sw_div_i),
    .sw_load_i (sw_load_i),
    .div_o     (div_o),
    .wren_o    (wren_o),
    .sat_o     (sat_o)
  );

  always #5 clk100 = ~clk100;

  // strobe must never be high on two consecutive cycles
  always @(negedge clk100) begin
    if (rstn && wren_o && prev_w) b2b <= b2b + 1;
    prev_w <= wren_o;
  end

  typedef struct {
    bit ld; int v; int ld_at; bit up; bit dn; int hold; bit bnc;
    int nwr; int lat; int val; bit sat;
  } vec_t;

  vec_t vec[14];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  // one transaction window; lat is the index of the edge after which wren_o was seen
  task automatic op(input bit ld, input int v, input int ld_at, input bit up, input bit dn,
                    input int hold, input bit bnc, output int nwr, output int lat, output int val);
    int win;
    bit lvl;
    nwr = 0; lat = -1; val = -1;
    win = (bnc ? 30 : 0) + hold + 24;
    @(negedge clk100);
    for (int k = 0; k < win; k++) begin
      sw_load_i = ld && (k == ld_at);
      sw_div_i  = 12'(v);
      if (bnc) lvl = (k < 30) ? (((k / 3) % 2) == 0) : (k < 30 + hold);
      else     lvl = (k < hold);
      btn_up_i = up && lvl;
      btn_dn_i = dn && lvl;
      @(posedge clk100); #1;
      if (wren_o) begin
        nwr++;
        val = int'(div_o);
        if (lat < 0) lat = k;
      end
    end
    sw_load_i = 1'b0; btn_up_i = 1'b0; btn_dn_i = 1'b0;
  endtask

  // count strobes for a few cycles after reset release
  task automatic after_release(input string nm);
    int nwr, lat, val;
    nwr = 0; lat = -1; val = -1;
    @(negedge clk100); rstn = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk100); #1;
      if (wren_o) begin nwr++; val = int'(div_o); if (lat < 0) lat = k; end
    end
    chk({nm, " nwr"}, nwr, 1);
    chk({nm, " lat"}, lat, 1);
    chk({nm, " val"}, val, 256);
    chk({nm, " sat"}, sat_o, 0);
  endtask

  initial begin
    int nwr, lat, val, m, e, kind, v;

    vec[0]  = '{0, 0,    0,  1, 0, 20, 0, 1, 13,  272, 0};
    vec[1]  = '{0, 0,    0,  0, 1, 20, 0, 1, 13,  256, 0};
    vec[2]  = '{0, 0,    0,  1, 0, 5,  0, 0, -1,  256, 0};
    vec[3]  = '{0, 0,    0,  1, 0, 20, 1, 1, 43,  272, 0};
    vec[4]  = '{1, 4090, 0,  0, 0, 1,  0, 1, 3,  4090, 0};
    vec[5]  = '{0, 0,    0,  1, 0, 20, 0, 1, 13, 4095, 1};
    vec[6]  = '{0, 0,    0,  1, 0, 20, 0, 0, -1, 4095, 1};
    vec[7]  = '{1, 0,    0,  0, 0, 1,  0, 1, 3,     1, 1};
    vec[8]  = '{0, 0,    0,  0, 1, 20, 0, 0, -1,    1, 1};
    vec[9]  = '{1, 200,  0,  0, 0, 1,  0, 1, 3,   200, 0};
    vec[10] = '{0, 0,    0,  1, 1, 20, 0, 0, -1,  200, 0};
    vec[11] = '{1, 100,  10, 1, 0, 20, 0, 1, 13,  100, 0};
    vec[12] = '{1, 10,   0,  0, 0, 1,  0, 1, 3,    10, 0};
    vec[13] = '{0, 0,    0,  0, 1, 20, 0, 1, 13,    1, 1};

    // reset state, then the single post-reset write
    #12;
    chk("reset wren", wren_o, 0);
    chk("reset div", div_o, 256);
    chk("reset sat", sat_o, 0);
    after_release("post-reset");
    repeat (10) @(posedge clk100);

    // directed table
    for (int i = 0; i < 14; i++) begin
      op(vec[i].ld, vec[i].v, vec[i].ld_at, vec[i].up, vec[i].dn, vec[i].hold, vec[i].bnc,
         nwr, lat, val);
      chk($sformatf("vec%0d nwr", i), nwr, vec[i].nwr);
      if (vec[i].nwr > 0) begin
        chk($sformatf("vec%0d lat", i), lat, vec[i].lat);
        chk($sformatf("vec%0d val", i), val, vec[i].val);
      end
      chk($sformatf("vec%0d div", i), div_o, vec[i].val);
      chk($sformatf("vec%0d sat", i), sat_o, vec[i].sat);
    end

    // random transactions against a saturating-arithmetic value model
    m = 1;
    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 2);
      case ($urandom_range(0, 3))
        0:       v = $urandom_range(0, 20);
        1:       v = $urandom_range(4075, 4095);
        default: v = $urandom_range(0, 4095);
      endcase
      if (kind == 0)      e = (v < 1) ? 1 : ((v > 4095) ? 4095 : v);
      else if (kind == 1) e = (m + 16 > 4095) ? 4095 : m + 16;
      else                e = (m - 16 < 1) ? 1 : m - 16;
      op(kind == 0, v, 0, kind == 1, kind == 2, 12, 0, nwr, lat, val);
      chk($sformatf("rnd%0d nwr", i), nwr, (e != m) ? 1 : 0);
      if (e != m) chk($sformatf("rnd%0d val", i), val, e);
      chk($sformatf("rnd%0d div", i), div_o, e);
      chk($sformatf("rnd%0d sat", i), sat_o, (e == 1 || e == 4095) ? 1 : 0);
      m = e;
    end

    // reset asserted during the WRITE cycle of a load
    op(1, 4000, 0, 0, 0, 1, 0, nwr, lat, val);
    chk("pre-abort div", div_o, 4000);
    @(negedge clk100); sw_div_i = 12'd300; sw_load_i = 1'b1;
    @(posedge clk100); #1 sw_load_i = 1'b0;
    @(posedge clk100);
    @(posedge clk100); #2;
    rstn = 1'b0; #1;
    chk("abort wren", wren_o, 0);
    chk("abort div", div_o, 256);
    chk("abort sat", sat_o, 0);
    @(negedge clk100);
    after_release("abort-release");
    repeat (10) @(posedge clk100); #1;
    chk("abort no replay div", div_o, 256);

    chk("wren gap", b2b, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/led_div_ctrl.md
# led_div_ctrl

Upstream control stage for the LED counter. Turns two raw pushbuttons (up/down) and a software load strobe into divider updates. Each update is emitted as a 12-bit `div_o` value with a single-cycle `wren_o` write strobe, which drive the counter's `div_i`/`wren_i` directly. It owns the current divider value, steps it with saturation, and clamps software loads to a legal range.

## Interface
- `DEBOUNCE_CYC`, 1000000, cycles a synchronized button level must stay stable before it is accepted (10 ms @ 100 MHz); min 2
- `DIV_W`, 12, divider width
- `DIV_MIN`, 1, lowest legal divider
- `DIV_MAX`, 4095, highest legal divider
- `DIV_STEP`, 16, increment/decrement per button press
- `DIV_INIT`, 256, divider value after reset
- `clk100`  in  1  system clock, 100 MHz
- `rstn`  in  1  reset, asynchronous assert, active-low
- `btn_up_i`  in  1  raw pushbutton, asynchronous, active-high
- `btn_dn_i`  in  1  raw pushbutton, asynchronous, active-high
- `sw_div_i`  in  DIV_W  software divider value, sampled with `sw_load_i`
- `sw_load_i`  in  1  single-cycle software load strobe, synchronous to `clk100`
- `div_o`  out  DIV_W  current divider value, registered
- `wren_o`  out  1  single-cycle write strobe; `div_o` is valid whenever this is high
- `sat_o`  out  1  high while `div_o` equals `DIV_MIN` or `DIV_MAX`

## Operation
- Clocking and reset: one clock and one asynchronous, active-low reset; everything is synchronous to `clk100`.
- Button synchronizer: each button passes through a 2-FF synchronizer.
- Debounce: a counter runs while the synchronized level differs from the debounced level and resets to 0 whenever the two match. When it reaches `DEBOUNCE_CYC-1`, the debounced level toggles.
- Press event: a rising edge of the debounced level. Release edges are ignored.
- Pending flags: press events and `sw_load_i` set sticky pending flags `p_up`, `p_dn` and `p_ld`. A `sw_load_i` pulse captures `sw_div_i` into `ld_val`; a later pulse overwrites it.
- FSM states: `INIT`, `IDLE`, `CALC`, `WRITE`.
- `INIT`: entered on reset release. Goes to `WRITE` with `div_o = DIV_INIT`, so the downstream counter is loaded once after reset.
- `IDLE`: if any pending flag is set, go to `CALC`.
- `CALC` selects one action, consumes the flags, and computes `nxt`:
  - `p_ld` has priority: `nxt = clamp(ld_val, DIV_MIN, DIV_MAX)`; `p_ld` is cleared, and `p_up`/`p_dn` are cleared as well.
  - If `p_up` and `p_dn` are both set without `p_ld`: both are cleared, with no change.
  - Otherwise `p_up` gives `nxt = min(div_o + DIV_STEP, DIV_MAX)`, and `p_dn` gives `nxt = max(div_o - DIV_STEP, DIV_MIN)`.
- Arithmetic width: performed in DIV_W+1 bits so overflow and underflow are detected before saturation.
- Unchanged result: if `nxt == div_o`, no write is issued and the FSM returns to `IDLE`. Otherwise it goes to `WRITE`.
- `WRITE`: for one cycle, `div_o <= nxt` and `wren_o = 1`. Then back to `IDLE`.
- Events during `CALC`/`WRITE`: they set pending flags and are served on the next pass through `IDLE`. None are lost, but repeated presses of the same button merge into one.

## Timing
- Reset values: `div_o = DIV_INIT`, `wren_o = 0`, `sat_o = (DIV_INIT==DIV_MIN || DIV_INIT==DIV_MAX)`. Internally, debounced levels, pending flags and counters are 0, and the FSM is in `INIT`.
- Reset mid-operation: any cycle with `rstn` low aborts the operation, drops pending events, and forces the reset values.
- Post-reset write: the first `wren_o` pulse occurs 2 cycles after `rstn` deasserts.
- Button latency: from the first `clk100` edge sampling a clean raw high to the `wren_o` pulse is `DEBOUNCE_CYC + 5` cycles, when the FSM is idle.
- Software load latency: `sw_load_i` at cycle N gives `wren_o` at N+3, when the FSM is idle.
- Strobe width: `wren_o` is never high for two consecutive cycles; the minimum gap is 2 cycles.
- `sat_o`: combinational from `div_o`, so it updates in the same cycle as `div_o`.

## Structure
- Package `led_div_pkg` holds:
  - the FSM state enum;
  - default parameter constants (`DIV_W`, `DIV_MIN`, `DIV_MAX`, `DIV_STEP`, `DIV_INIT`, `DEBOUNCE_CYC`).
- Sub-module `btn_debounce(DEBOUNCE_CYC)` contains the synchronizer, debounce counter and rising-edge detector, and outputs `press_o`. It is instantiated twice, once per button.
- The top level contains the pending flags, FSM and datapath.

## Test plan
All scenarios use `DEBOUNCE_CYC=8`.
- **Reset:** release `rstn` → `wren_o` pulses once 2 cycles later with `div_o=256`; `sat_o=0`.
- **Single up press:** hold `btn_up_i` 20 cycles → one `wren_o` with `div_o=272`. Then `btn_dn_i` held 20 cycles → one `wren_o` with `div_o=256`.
- **Glitch rejection:**
  - a `btn_up_i` pulse of 5 cycles → no `wren_o`, `div_o` stays 256;
  - bouncing for 30 cycles (toggle every 3 cycles) then a stable high → exactly one `wren_o`.
- **Saturation:**
  - `sw_load_i` with `sw_div_i=4090` → `div_o=4090`; an up press → `4095`, `sat_o=1`; a further up press → no `wren_o`.
  - `sw_div_i=0` load → `div_o=1`, `sat_o=1`.
- **Simultaneous events:**
  - up and down pressed in the same cycle → no `wren_o`;
  - `sw_load_i` (value 100) in the same cycle as an up press → single write with `div_o=100`.
- **Reset mid-operation:** assert `rstn` low in the `WRITE` cycle of a load → `wren_o=0` and `div_o=256` immediately. After release, one post-reset `wren_o` with 256 and no replay of the aborted load.
